// File: rtl/freq_divider_prog.sv
// -----------------------------------------------------------------------------
// freq_divider_prog
//   Programmable clock divider / pulse generator / PWM.
//   A counter runs 0..active_div while enabled, so one period is D+1 cycles.
//   New settings are captured into a pending shadow by 'load' and become
//   active at the next period boundary (or at once when the counter is
//   stopped). Outputs are all registered.
//
// Parameters
//   WIDTH      width of counter, divisor and duty fields
//   RESET_DIV  divisor in use after reset
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   en         count enable (low = hold everything, tick forced low)
//   load       strobe: capture div_in/duty_in/mode_in into the pending shadow
//   div_in     requested terminal count D (period D+1)
//   duty_in    requested high time in cycles (duty mode)
//   mode_in    0 toggle, 1 pulse, 2 duty, 3 treated as toggle
//   clkdiv     divided clock / pulse / PWM output
//   tick       one-cycle strobe after each completed period
//   load_ack   one-cycle strobe after pending settings become active
//   active_div divisor currently in use
// -----------------------------------------------------------------------------
module freq_divider_prog #(
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 249
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic [1:0]       mode_in,
  output logic             clkdiv,
  output logic             tick,
  output logic             load_ack,
  output logic [WIDTH-1:0] active_div
);

  localparam logic [1:0]       MODE_PULSE  = 2'd1;
  localparam logic [1:0]       MODE_DUTY   = 2'd2;
  localparam logic [WIDTH-1:0] RESET_DIV_C = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ZERO_C      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C       = {{(WIDTH-1){1'b0}}, 1'b1};

  // Counter and active configuration
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic [WIDTH-1:0] duty_q,  duty_d;
  logic [1:0]       mode_q,  mode_d;
  // Pending shadow configuration
  logic [WIDTH-1:0] pdiv_q,  pdiv_d;
  logic [WIDTH-1:0] pduty_q, pduty_d;
  logic [1:0]       pmode_q, pmode_d;
  logic             pend_q,  pend_d;
  // Registered outputs
  logic             clkdiv_q, clkdiv_d;
  logic             tick_q,   tick_d;
  logic             ack_q,    ack_d;

  logic             wrap_s;
  logic             apply_s;

  // Next-state logic: counting, apply of pending settings, output generation
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    duty_d   = duty_q;
    mode_d   = mode_q;
    pdiv_d   = pdiv_q;
    pduty_d  = pduty_q;
    pmode_d  = pmode_q;
    pend_d   = pend_q;
    clkdiv_d = clkdiv_q;

    wrap_s  = en && (cnt_q == div_q);
    // Running: swap in at a period boundary. Stopped: swap in at once.
    apply_s = pend_q && (wrap_s || !en);

    tick_d = wrap_s;
    ack_d  = apply_s;

    // The apply edge already uses the new settings, so the new mode and duty
    // shape clkdiv from the very first cycle of the new period.
    if (apply_s) begin
      div_d  = pdiv_q;
      duty_d = pduty_q;
      mode_d = pmode_q;
      cnt_d  = ZERO_C;
    end else if (en) begin
      if (wrap_s) begin
        cnt_d = ZERO_C;
      end else begin
        cnt_d = cnt_q + ONE_C;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (en) begin
      case (mode_d)
        MODE_PULSE: clkdiv_d = wrap_s;
        MODE_DUTY:  clkdiv_d = (cnt_d < duty_d);
        // Toggle mode (and the reserved code): flip on each period end and
        // keep the current level across an apply.
        default: begin
          if (wrap_s) begin
            clkdiv_d = ~clkdiv_q;
          end else begin
            clkdiv_d = clkdiv_q;
          end
        end
      endcase
    end else begin
      clkdiv_d = clkdiv_q;
    end

    // The shadow is refilled after the apply decision, so a load on the
    // apply edge becomes the next pending set rather than being lost.
    if (load) begin
      pdiv_d  = div_in;
      pduty_d = duty_in;
      pmode_d = mode_in;
      pend_d  = 1'b1;
    end else if (apply_s) begin
      pend_d  = 1'b0;
    end else begin
      pend_d  = pend_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= ZERO_C;
      div_q    <= RESET_DIV_C;
      duty_q   <= ZERO_C;
      mode_q   <= 2'd0;
      pdiv_q   <= ZERO_C;
      pduty_q  <= ZERO_C;
      pmode_q  <= 2'd0;
      pend_q   <= 1'b0;
      clkdiv_q <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      duty_q   <= duty_d;
      mode_q   <= mode_d;
      pdiv_q   <= pdiv_d;
      pduty_q  <= pduty_d;
      pmode_q  <= pmode_d;
      pend_q   <= pend_d;
      clkdiv_q <= clkdiv_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
    end
  end

  assign clkdiv     = clkdiv_q;
  assign tick       = tick_q;
  assign load_ack   = ack_q;
  assign active_div = div_q;

endmodule

// File: tb/tb_freq_divider_prog.sv
// -----------------------------------------------------------------------------
// tb_freq_divider_prog
//   Self-checking bench for freq_divider_prog. A period/phase model with a
//   pending-settings queue predicts every output after each rising edge;
//   directed scenarios add aggregate counts over whole periods.
// -----------------------------------------------------------------------------
module tb_freq_divider_prog;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] div_in;
  logic [W-1:0] duty_in;
  logic [1:0]   mode_in;
  logic         clkdiv;
  logic         tick;
  logic         load_ack;
  logic [W-1:0] active_div;

  freq_divider_prog #(.WIDTH(W), .RESET_DIV(249)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .div_in     (div_in),
    .duty_in    (duty_in),
    .mode_in    (mode_in),
    .clkdiv     (clkdiv),
    .tick       (tick),
    .load_ack   (load_ack),
    .active_div (active_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    int div;
    int duty;
    int mode;
  } cfg_t;

  // Reference model state
  cfg_t m_cfg;
  cfg_t m_pend[$];
  int   m_phase;   // position inside the current period, 0..div
  bit   m_clk;
  bit   m_tick;
  bit   m_ack;

  int   checks = 0;
  int   errors = 0;
  int   n_tick, n_high, n_ack, n_tog;
  logic prev_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg   = '{div: 249, duty: 0, mode: 0};
    m_pend.delete();
    m_phase = 0;
    m_clk   = 1'b0;
    m_tick  = 1'b0;
    m_ack   = 1'b0;
  endtask

  // One rising edge of the reference model.
  task automatic model_step(input bit e, input bit l, input cfg_t nc);
    bit period_end;
    bit take;
    int md;
    period_end = e && (m_phase == m_cfg.div);
    take       = (m_pend.size() > 0) && (period_end || !e);
    if (take) begin
      m_cfg   = m_pend.pop_front();
      m_phase = 0;
    end else if (e) begin
      m_phase = (m_phase + 1) % (m_cfg.div + 1);
    end
    if (e) begin
      md = (m_cfg.mode == 3) ? 0 : m_cfg.mode;
      if (md == 1)       m_clk = period_end;
      else if (md == 2)  m_clk = (m_phase < m_cfg.duty);
      else if (period_end) m_clk = !m_clk;
    end
    m_tick = period_end;
    m_ack  = take;
    if (l) begin
      m_pend.delete();
      m_pend.push_back(nc);
    end
  endtask

  task automatic clear_stats();
    n_tick = 0; n_high = 0; n_ack = 0; n_tog = 0;
    prev_clk = clkdiv;
  endtask

  // Drive one cycle of inputs, step DUT and model, compare every output.
  task automatic cycle(input bit e, input bit l, input int d, input int du, input int mo);
    cfg_t nc;
    @(negedge clk);
    en      = e;
    load    = l;
    div_in  = W'(d);
    duty_in = W'(du);
    mode_in = 2'(mo);
    nc = '{div: d, duty: du, mode: mo};
    @(posedge clk);
    model_step(e, l, nc);
    #1;
    check_eq("clkdiv",     clkdiv,     m_clk);
    check_eq("tick",       tick,       m_tick);
    check_eq("load_ack",   load_ack,   m_ack);
    check_eq("active_div", active_div, m_cfg.div);
    n_tick += tick;
    n_high += clkdiv;
    n_ack  += load_ack;
    n_tog  += (clkdiv != prev_clk) ? 1 : 0;
    prev_clk = clkdiv;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic load_cfg(input int d, input int du, input int mo);
    cycle(1'b1, 1'b1, d, du, mo);
  endtask

  task automatic wait_ack(input int bound, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      cycle(1'b1, 1'b0, 0, 0, 0);
      if (load_ack === 1'b1) got = 1'b1;
    end
    check_eq(tag, got, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    #1;
    model_reset();
    check_eq("rst_clkdiv",     clkdiv,     0);
    check_eq("rst_tick",       tick,       0);
    check_eq("rst_load_ack",   load_ack,   0);
    check_eq("rst_active_div", active_div, 249);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_clkdiv", clkdiv, 0);
    check_eq("rst_hold_tick",   tick,   0);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c0;
    reset = 1'b0; en = 1'b0; load = 1'b0;
    div_in = '0; duty_in = '0; mode_in = 2'd0;
    model_reset();

    // Default divider after reset: period 500, tick every 250
    do_reset();
    clear_stats();
    run(500);
    check_eq("def_ticks",   n_tick, 2);
    check_eq("def_toggles", n_tog,  2);
    check_eq("def_high",    n_high, 250);
    check_eq("def_div",     active_div, 249);
    run(100);

    // Mid-period load D=3 pulse mode
    load_cfg(3, 0, 1);
    check_eq("mid_no_early_ack", load_ack, 0);
    wait_ack(300, "d3_ack");
    check_eq("d3_div", active_div, 3);
    clear_stats();
    run(40);
    check_eq("d3_ticks", n_tick, 10);
    check_eq("d3_high",  n_high, 10);
    check_eq("d3_acks",  n_ack,  0);

    // Duty mode D=9 with duty 3, 0, 12
    load_cfg(9, 3, 2);
    wait_ack(20, "duty3_ack");
    clear_stats(); run(20);
    check_eq("duty3_high", n_high, 6);
    load_cfg(9, 0, 2);
    wait_ack(20, "duty0_ack");
    clear_stats(); run(20);
    check_eq("duty0_high", n_high, 0);
    load_cfg(9, 12, 2);
    wait_ack(20, "duty12_ack");
    clear_stats(); run(20);
    check_eq("duty12_high", n_high, 20);

    // Two loads before a wrap: last wins, single ack
    clear_stats();
    load_cfg(5, 0, 0);
    load_cfg(7, 0, 0);
    run(40);
    check_eq("two_load_acks", n_ack, 1);
    check_eq("two_load_div",  active_div, 7);
    clear_stats(); run(32);
    check_eq("d7_ticks",   n_tick, 4);
    check_eq("d7_toggles", n_tog,  4);

    // D=0: pulse mode constantly high, toggle mode clk/2
    load_cfg(0, 0, 1);
    wait_ack(20, "d0p_ack");
    clear_stats(); run(10);
    check_eq("d0p_high",  n_high, 10);
    check_eq("d0p_ticks", n_tick, 10);
    load_cfg(0, 0, 0);
    wait_ack(20, "d0t_ack");
    clear_stats(); run(10);
    check_eq("d0t_toggles", n_tog, 10);

    // Stopped counter: load applies on the next edge, outputs hold
    load_cfg(6, 0, 0);
    wait_ack(20, "pre_en0_ack");
    run(3);
    cycle(1'b0, 1'b1, 1, 0, 0);
    check_eq("en0_tick", tick, 0);
    cycle(1'b0, 1'b0, 0, 0, 0);
    check_eq("en0_ack", load_ack, 1);
    check_eq("en0_div", active_div, 1);
    c0 = clkdiv;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0, 0, 0);
    check_eq("en0_clk_hold", clkdiv, c0);
    clear_stats(); run(16);
    check_eq("en1_d1_toggles", n_tog,  8);
    check_eq("en1_d1_ticks",   n_tick, 8);

    // Reset with a pending load discards it
    run(1);
    load_cfg(20, 0, 1);
    do_reset();
    clear_stats(); run(300);
    check_eq("post_rst_acks",  n_ack, 0);
    check_eq("post_rst_div",   active_div, 249);
    check_eq("post_rst_ticks", n_tick, 1);

    // Randomised traffic against the model
    load_cfg(4, 2, 2);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 12)),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_divider_prog.md
FREQ_DIVIDER_PROG -- requirements
Module: freq_divider_prog

Interface
REQ-001 Parameter WIDTH, default 16: width of counter, divisor and duty fields.
REQ-002 Parameter RESET_DIV, default 249: active divisor value loaded at reset.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; high = run, low = hold.
REQ-006 load  input  1  one-cycle strobe; capture div_in/duty_in/mode_in into pending shadow.
REQ-007 div_in  input  WIDTH  requested terminal count D; period = D+1 clk cycles.
REQ-008 duty_in  input  WIDTH  requested high time in cycles (duty mode only).
REQ-009 mode_in  input  2  requested mode: 0 toggle, 1 pulse, 2 duty, 3 reserved (behaves as 0).
REQ-010 clkdiv  output  1  divided clock / PWM output, registered.
REQ-011 tick  output  1  one-cycle strobe per completed period, registered.
REQ-012 load_ack  output  1  one-cycle strobe when pending config becomes active.
REQ-013 active_div  output  WIDTH  divisor currently in use.

Function
REQ-014 Counter q (WIDTH bits) SHALL count 0..active_div when en=1, wrapping to 0 at the edge where q==active_div ("wrap edge"); no other wrap point.
REQ-015 en=0: q, clkdiv and all active registers SHALL hold; tick SHALL be 0.
REQ-016 Every wrap edge SHALL set tick=1 for exactly the following cycle; otherwise tick=0.
REQ-017 Mode 0: clkdiv SHALL invert at each wrap edge; output period 2*(D+1) cycles, 50% duty.
REQ-018 Mode 1: clkdiv SHALL equal tick (one-cycle high pulse every D+1 cycles).
REQ-019 Mode 2: at each enabled edge clkdiv SHALL load (q_next < active_duty); active_duty=0 -> constant 0; active_duty>D -> constant 1.
REQ-020 D=0: wrap every enabled cycle; mode 0 gives clk/2, mode 1 gives tick and clkdiv constantly 1.
REQ-021 load=1 SHALL copy div_in, duty_in, mode_in into pending registers and set pending flag; a later load before apply overwrites pending (last wins).
REQ-022 Pending config SHALL become active at the first wrap edge strictly after the load cycle; load coincident with a wrap edge applies at the next wrap edge.
REQ-023 If en=0 and pending flag set, pending config SHALL become active at the next edge and q SHALL reset to 0.
REQ-024 On apply: active registers update, q=0, pending cleared, load_ack=1 for exactly one cycle; mode 0 clkdiv continues toggling from its current level (no forced phase).
REQ-025 load coincident with apply edge: apply uses the older pending values; new values become pending (no lost load).
REQ-026 Mode change into mode 2 SHALL take effect from the apply edge using new duty; no glitch shorter than one clk cycle on clkdiv in any mode.

Reset
REQ-027 reset=1 SHALL immediately force q=0, active_div=RESET_DIV, active_duty=0, active mode=0, pending=0, clkdiv=0, tick=0, load_ack=0.
REQ-028 reset asserted mid-period or with load pending SHALL discard pending config; after release counting restarts from q=0 on the first enabled edge.

Verification
REQ-029 Reset, en=1, no load, WIDTH=16: clkdiv toggles every 250 cycles (period 500), tick every 250 cycles, active_div=249.
REQ-030 load D=3, mode 1 mid-period: change only after current period ends; load_ack one cycle at that wrap; thereafter tick/clkdiv high 1 of every 4 cycles.
REQ-031 Mode 2, D=9, duty 3/0/12: clkdiv high 3 of 10 cycles / always low / always high.
REQ-032 Two loads (D=5 then D=7) before a wrap: single load_ack, active_div=7, period 8 cycles.
REQ-033 en=0 with load D=1: applies next edge with load_ack; q and clkdiv hold while en=0; mode 0 resumes at clk/4 when en=1.
REQ-034 reset pulsed mid-period with pending load: all outputs zero during reset; after release active_div=249, no load_ack.
